// File: rtl/fb_pixel_writer_pkg.sv
// Shared frame-buffer constants and types used by the writer, the display reader
// and the timing generator.
package fb_pixel_writer_pkg;

   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned V_ACTIVE = 600;
   localparam int unsigned H_TOTAL  = 1040;
   localparam int unsigned V_TOTAL  = 666;
   localparam int unsigned ADDR_W   = 19;
   localparam int unsigned CNT_W    = 10;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef enum logic [2:0] {
      StIdle,
      StGetR,
      StGetG,
      StGetB,
      StWrite
   } state_e;

   function automatic logic [23:0] pixel_to_word(input pixel_t p);
      return {p.r, p.g, p.b};
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster position tracker: x/y counters plus a linear address that is simply
// incremented per pixel, so no y*H_ACTIVE multiply is needed.
module fb_addr_gen
   import fb_pixel_writer_pkg::*;
#(
   parameter int unsigned HActive = H_ACTIVE,
   parameter int unsigned VActive = V_ACTIVE,
   parameter int unsigned AddrW   = ADDR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [AddrW-1:0] addr_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] XLast = CNT_W'(HActive - 1);
   localparam logic [CNT_W-1:0] YLast = CNT_W'(VActive - 1);

   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic [AddrW-1:0] addr_q, addr_d;

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
      if (clr_i) begin
         x_d    = '0;
         y_d    = '0;
         addr_d = '0;
      end else if (inc_i) begin
         if (x_q == XLast) begin
            x_d = '0;
            y_d = y_q + CNT_W'(1);
         end else begin
            x_d = x_q + CNT_W'(1);
         end
         addr_d = addr_q + AddrW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (x_q == XLast) && (y_q == YLast);

endmodule

// File: rtl/fb_pixel_writer.sv
// Assembles R,G,B bytes from a stream into 24-bit pixels and writes them in raster
// order to the frame-buffer write port, resynchronising on in_sof.
module fb_pixel_writer
   import fb_pixel_writer_pkg::*;
#(
   parameter int unsigned HActive = H_ACTIVE,
   parameter int unsigned VActive = V_ACTIVE,
   parameter int unsigned AddrW   = ADDR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic             in_ready,
   output logic             wr_en,
   output logic [AddrW-1:0] wr_addr,
   output logic [23:0]      wr_data,
   input  logic             wr_ready,
   output logic             busy,
   output logic             frame_done,
   output logic             sync_err
);

   state_e state_q, state_d;
   pixel_t pix_q, pix_d;
   logic   frame_done_q, frame_done_d;
   logic   sync_err_q, sync_err_d;
   logic   addr_clr, addr_inc, last_pix;
   logic   byte_acc, wr_acc;

   assign byte_acc = in_valid && in_ready;
   assign wr_acc   = wr_en && wr_ready;

   fb_addr_gen #(
      .HActive (HActive),
      .VActive (VActive),
      .AddrW   (AddrW)
   ) u_addr_gen (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (addr_clr),
      .inc_i  (addr_inc),
      .addr_o (wr_addr),
      .last_o (last_pix)
   );

   always_comb begin
      state_d      = state_q;
      pix_d        = pix_q;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      addr_clr     = 1'b0;
      addr_inc     = 1'b0;
      // A start-of-frame byte restarts the frame from any byte-accepting state.
      if (byte_acc && in_sof) begin
         pix_d.r    = in_data;
         addr_clr   = 1'b1;
         sync_err_d = (state_q != StIdle);
         state_d    = StGetG;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StIdle;
            end
            StGetR: begin
               if (byte_acc) begin
                  pix_d.r = in_data;
                  state_d = StGetG;
               end
            end
            StGetG: begin
               if (byte_acc) begin
                  pix_d.g = in_data;
                  state_d = StGetB;
               end
            end
            StGetB: begin
               if (byte_acc) begin
                  pix_d.b = in_data;
                  state_d = StWrite;
               end
            end
            StWrite: begin
               if (wr_acc) begin
                  if (last_pix) begin
                     addr_clr     = 1'b1;
                     frame_done_d = 1'b1;
                     state_d      = StIdle;
                  end else begin
                     addr_inc = 1'b1;
                     state_d  = StGetR;
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         pix_q        <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_q        <= pix_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign in_ready   = (state_q != StWrite);
   assign wr_en      = (state_q == StWrite);
   assign busy       = (state_q != StIdle);
   assign wr_data    = pixel_to_word(pix_q);
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer on an 800x3 frame: stream-level model plus directed
// literal checks for reset, latency, line wrap, write stall, resync and frame end.
module tb_fb_pixel_writer;
   import fb_pixel_writer_pkg::*;

   localparam int H    = 800;
   localparam int V    = 3;
   localparam int NPIX = H * V;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic        wr_en;
   logic [18:0] wr_addr;
   logic [23:0] wr_data;
   logic        wr_ready;
   logic        busy;
   logic        frame_done;
   logic        sync_err;

   int n_cmp = 0;
   int n_err = 0;

   fb_pixel_writer #(
      .HActive (H),
      .VActive (V),
      .AddrW   (19)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .busy       (busy),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- stream-level model ----------------
   typedef struct {
      int          addr;
      logic [23:0] data;
      bit          last;
   } exp_t;

   exp_t        q[$];
   bit          m_valid = 0;
   bit          m_in_frame;
   int          m_cnt;
   int          m_pix;
   logic [7:0]  m_r, m_g;
   bit          exp_wr, exp_done, exp_sync;

   always @(negedge clk) begin
      exp_t e;
      bit   n_wr, n_done, n_sync;
      if (m_valid) begin
         chk("wr_en", 32'(wr_en), 32'(exp_wr));
         chk("in_ready", 32'(in_ready), 32'(!exp_wr));
         chk("busy", 32'(busy), 32'(m_in_frame));
         chk("frame_done", 32'(frame_done), 32'(exp_done));
         chk("sync_err", 32'(sync_err), 32'(exp_sync));
         if (wr_en) begin
            if (q.size() == 0) chk("write_not_expected", 32'(wr_en), 32'd0);
            else begin
               chk("wr_addr", 32'(wr_addr), 32'(q[0].addr));
               chk("wr_data", 32'(wr_data), 32'(q[0].data));
            end
         end
      end
      if (reset) begin
         m_valid = 1; m_in_frame = 0; m_cnt = 0; m_pix = 0;
         exp_wr = 0; exp_done = 0; exp_sync = 0;
         q.delete();
      end else if (m_valid) begin
         n_wr = 0; n_done = 0; n_sync = 0;
         if (wr_en && q.size() != 0) begin
            if (wr_ready) begin
               e = q.pop_front();
               if (e.last) begin
                  n_done = 1;
                  m_in_frame = 0;
               end
            end else begin
               n_wr = 1;
            end
         end
         if (in_valid && in_ready) begin
            if (in_sof) begin
               n_sync = m_in_frame;
               m_in_frame = 1; m_pix = 0; m_cnt = 1; m_r = in_data;
            end else if (m_in_frame) begin
               if (m_cnt == 0) begin m_r = in_data; m_cnt = 1; end
               else if (m_cnt == 1) begin m_g = in_data; m_cnt = 2; end
               else begin
                  e.addr = m_pix; e.data = {m_r, m_g, in_data}; e.last = (m_pix == NPIX - 1);
                  q.push_back(e);
                  m_pix++; m_cnt = 0; n_wr = 1;
               end
            end
         end
         exp_wr = n_wr; exp_done = n_done; exp_sync = n_sync;
      end
   end

   // ---------------- stimulus ----------------
   function automatic int gap();
      return int'($urandom_range(0, 1));
   endfunction

   function automatic logic [23:0] pix_of(input int i, input logic [7:0] salt);
      logic [23:0] v;
      v[23:16] = 8'(i);
      v[15:8]  = 8'(i >> 8) ^ salt;
      v[7:0]   = 8'(i * 7) ^ 8'h3c;
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic sof, input int g);
      int t;
      in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = d; in_sof = sof;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
      chk({tag, "_state"}, 32'(dut.state_q), 32'(StIdle));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] p;
      reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk); #1;

      // First pixel: 0x12 0x34 0x56 -> single write at address 0.
      send_byte(8'h12, 1'b1, 0);
      send_byte(8'h34, 1'b0, 0);
      send_byte(8'h56, 1'b0, 0);
      @(negedge clk);
      chk("px0_wr_en", 32'(wr_en), 32'd1);
      chk("px0_wr_addr", 32'(wr_addr), 32'd0);
      chk("px0_wr_data", 32'(wr_data), 32'h123456);
      chk("px0_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("px0_after_wr_en", 32'(wr_en), 32'd0);
      chk("px0_after_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      for (int i = 1; i < 10; i++) begin
         p = pix_of(i, 8'h11);
         send_byte(p[23:16], 1'b0, 0);
         send_byte(p[15:8], 1'b0, 0);
         send_byte(p[7:0], 1'b0, 0);
      end

      // Pixel 10: sof on the G byte restarts the frame with that byte as R.
      send_byte(8'hAA, 1'b0, 0);
      send_byte(8'hBB, 1'b1, 0);
      @(negedge clk);
      chk("resync_sync_err", 32'(sync_err), 32'd1);
      chk("resync_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      send_byte(8'hCC, 1'b0, 0);
      send_byte(8'hDD, 1'b0, 0);
      @(negedge clk);
      chk("resync_wr_addr", 32'(wr_addr), 32'd0);
      chk("resync_wr_data", 32'(wr_data), 32'hBBCCDD);
      @(posedge clk); #1;

      // Remainder of the resynchronised frame with random input gaps.
      for (int i = 1; i < NPIX; i++) begin
         p = pix_of(i, 8'h5a);
         send_byte(p[23:16], 1'b0, gap());
         send_byte(p[15:8], 1'b0, gap());
         if (i == H - 1) begin
            wr_ready = 1'b0;
            send_byte(p[7:0], 1'b0, 0);
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               chk("stall_wr_en", 32'(wr_en), 32'd1);
               chk("stall_wr_addr", 32'(wr_addr), 32'(H - 1));
               chk("stall_wr_data", 32'(wr_data), 32'(p));
               chk("stall_in_ready", 32'(in_ready), 32'd0);
               @(posedge clk); #1;
               if (k == 4) wr_ready = 1'b1;
            end
            @(negedge clk);
            chk("wrap_x", 32'(dut.u_addr_gen.x_q), 32'd0);
            chk("wrap_y", 32'(dut.u_addr_gen.y_q), 32'd1);
            chk("wrap_wr_en", 32'(wr_en), 32'd0);
            @(posedge clk); #1;
         end else if (i == H) begin
            send_byte(p[7:0], 1'b0, 0);
            @(negedge clk);
            chk("px800_wr_addr", 32'(wr_addr), 32'd800);
            chk("px800_wr_data", 32'(wr_data), 32'(p));
            @(posedge clk); #1;
         end else if (i == NPIX - 1) begin
            send_byte(p[7:0], 1'b0, 0);
            @(negedge clk);
            chk("last_wr_en", 32'(wr_en), 32'd1);
            chk("last_wr_addr", 32'(wr_addr), 32'(NPIX - 1));
            @(posedge clk); #1;
            @(negedge clk);
            chk("last_frame_done", 32'(frame_done), 32'd1);
            chk("last_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_pulse_end", 32'(frame_done), 32'd0);
            @(posedge clk); #1;
         end else begin
            send_byte(p[7:0], 1'b0, gap());
         end
      end
      chk("queue_drained", 32'(q.size()), 32'd0);

      // Reset in GET_G with a byte held valid; a following non-sof byte is dropped.
      send_byte(8'h99, 1'b1, 0);
      in_valid = 1'b1; in_data = 8'h77; in_sof = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      @(negedge clk);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_wr_en", 32'(wr_en), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
